store_lane_packer: RTL and testbench

Store-side counterpart of the immediate/load extension path in the RV32IM core. It takes a store of byte, halfword or word size from the execute stage and narrows it to that size. It places the data on the correct byte lanes of a 32-bit word-addressed data memory and drives the matching byte enables. It also runs the request/grant handshake to memory, splitting misaligned stores into two word-aligned beats when configured to.

---
 rtl/store_lane_packer.sv | 192 +++++++++++++++++++
 tb/tb_store_lane_packer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/store_lane_packer.sv
// Store lane packer: narrows execute-stage stores to byte/half/word and writes them to memory.
// Define MISALIGN_SPLIT_EN to split misaligned stores into two word-aligned beats.
module store_lane_packer #(
    parameter int Data_Width = 32,
    parameter int Addr_Width = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  st_valid,
    output logic                  st_ready,
    input  logic [Addr_Width-1:0] st_addr,
    input  logic [Data_Width-1:0] st_data,
    input  logic [1:0]            st_size,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic [Addr_Width-1:0] mem_addr,
    output logic [Data_Width-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    output logic                  st_done,
    output logic                  st_err
);

    typedef enum logic [1:0] {
        IDLE,
        BEAT0,
        BEAT1,
        RESP
    } state_t;

    state_t state, state_n;

    logic                  rdy_q;
    logic                  err_q;
    logic [Addr_Width-3:0] wa_q;
    logic [Data_Width-1:0] lo_d_q;
    logic [3:0]            lo_be_q;
`ifdef MISALIGN_SPLIT_EN
    logic [Data_Width-1:0] hi_d_q;
    logic [3:0]            hi_be_q;
    localparam logic [Addr_Width-3:0] WORD_ONE = 1;
`endif

    logic                  xfer;
    logic                  bad;
    logic [1:0]            off;
    logic [3:0]            mask;
    logic [Data_Width-1:0] trunc;
    logic [7:0]            be8;
`ifdef MISALIGN_SPLIT_EN
    logic [2*Data_Width-1:0] d64;
`else
    logic [Data_Width-1:0]   d32;
`endif

    assign off  = st_addr[1:0];
    assign xfer = st_valid && rdy_q;

    always_comb begin
        mask  = 4'b0000;
        trunc = '0;
        case (st_size)
            2'b00: begin
                mask  = 4'b0001;
                trunc = {{(Data_Width-8){1'b0}}, st_data[7:0]};
            end
            2'b01: begin
                mask  = 4'b0011;
                trunc = {{(Data_Width-16){1'b0}}, st_data[15:0]};
            end
            2'b10: begin
                mask  = 4'b1111;
                trunc = st_data;
            end
            default: begin
                mask  = 4'b0000;
                trunc = '0;
            end
        endcase
    end

    assign be8 = {4'b0000, mask} << off;

`ifdef MISALIGN_SPLIT_EN
    assign d64 = {{Data_Width{1'b0}}, trunc} << {off, 3'b000};
    assign bad = (st_size == 2'b11);
`else
    // Any lane spill past the word boundary is a misaligned store.
    assign d32 = trunc << {off, 3'b000};
    assign bad = (st_size == 2'b11) || (|be8[7:4]);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (xfer) begin
                    state_n = bad ? RESP : BEAT0;
                end
            end
            BEAT0: begin
                if (mem_gnt) begin
`ifdef MISALIGN_SPLIT_EN
                    state_n = (|hi_be_q) ? BEAT1 : RESP;
`else
                    state_n = RESP;
`endif
                end
            end
`ifdef MISALIGN_SPLIT_EN
            BEAT1: begin
                if (mem_gnt) begin
                    state_n = RESP;
                end
            end
`endif
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Ready is registered so it stays low through reset and rises one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
            wa_q    <= '0;
            lo_d_q  <= '0;
            lo_be_q <= 4'b0000;
`ifdef MISALIGN_SPLIT_EN
            hi_d_q  <= '0;
            hi_be_q <= 4'b0000;
`endif
        end else begin
            rdy_q <= (state_n == IDLE);
            if (xfer) begin
                err_q   <= bad;
                wa_q    <= st_addr[Addr_Width-1:2];
                lo_be_q <= be8[3:0];
`ifdef MISALIGN_SPLIT_EN
                lo_d_q  <= d64[Data_Width-1:0];
                hi_d_q  <= d64[2*Data_Width-1:Data_Width];
                hi_be_q <= be8[7:4];
`else
                lo_d_q  <= d32;
`endif
            end
        end
    end

    assign st_ready = rdy_q;

    always_comb begin
        mem_req   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = 4'b0000;
        st_done   = 1'b0;
        st_err    = 1'b0;
        case (state)
            BEAT0: begin
                mem_req   = 1'b1;
                mem_addr  = {wa_q, 2'b00};
                mem_wdata = lo_d_q;
                mem_be    = lo_be_q;
            end
`ifdef MISALIGN_SPLIT_EN
            BEAT1: begin
                mem_req   = 1'b1;
                mem_addr  = {wa_q + WORD_ONE, 2'b00};
                mem_wdata = hi_d_q;
                mem_be    = hi_be_q;
            end
`endif
            RESP: begin
                st_done = !err_q;
                st_err  = err_q;
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_store_lane_packer.sv
// Directed bench for store_lane_packer; MISALIGN_SPLIT_EN selects the split-store expectations.
// Inputs change and outputs are sampled on the falling edge.
module tb_store_lane_packer;

    logic        clk;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_size;
    logic        mem_req;
    logic        mem_gnt;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        st_done;
    logic        st_err;

    int checks   = 0;
    int failures = 0;

    store_lane_packer #(
        .Data_Width(32),
        .Addr_Width(32)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .st_valid (st_valid),
        .st_ready (st_ready),
        .st_addr  (st_addr),
        .st_data  (st_data),
        .st_size  (st_size),
        .mem_req  (mem_req),
        .mem_gnt  (mem_gnt),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_be   (mem_be),
        .st_done  (st_done),
        .st_err   (st_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic beat(input string tag, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] d);
        chk({tag, "_req"}, {31'd0, mem_req}, 32'd1);
        chk({tag, "_addr"}, mem_addr, a);
        chk({tag, "_be"}, {28'd0, mem_be}, {28'd0, be});
        chk({tag, "_wdata"}, mem_wdata, d);
        chk({tag, "_rdy"}, {31'd0, st_ready}, 32'd0);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_size  = sz;
        @(negedge clk);
        st_valid = 1'b0;
        st_addr  = 32'h0;
        st_data  = 32'h0;
        st_size  = 2'b00;
    endtask

    initial begin
        rst_n    = 1'b0;
        st_valid = 1'b0;
        st_addr  = 32'h0;
        st_data  = 32'h0;
        st_size  = 2'b00;
        mem_gnt  = 1'b0;

        @(negedge clk);
        chk("rst_ready", {31'd0, st_ready}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_be", {28'd0, mem_be}, 32'd0);
        chk("rst_done_err", {30'd0, st_done, st_err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, st_ready}, 32'd1);

        // Byte store, grant immediate; stray grant while idle must be ignored
        mem_gnt = 1'b1;
        @(negedge clk);
        chk("idle_gnt_req", {31'd0, mem_req}, 32'd0);
        issue(32'h0000_1003, 32'hDEAD_BEEF, 2'b00);
        beat("byte", 32'h0000_1000, 4'b1000, 32'hEF00_0000);
        @(negedge clk);
        chk("byte_done", {31'd0, st_done}, 32'd1);
        chk("byte_err", {31'd0, st_err}, 32'd0);
        chk("byte_resp_req", {31'd0, mem_req}, 32'd0);
        chk("byte_resp_rdy", {31'd0, st_ready}, 32'd0);
        @(negedge clk);
        chk("byte_rdy_back", {31'd0, st_ready}, 32'd1);
        chk("byte_done_drop", {31'd0, st_done}, 32'd0);

        // Half store with grant held low for three cycles
        mem_gnt = 1'b0;
        issue(32'h0000_2002, 32'h1234_ABCD, 2'b01);
        for (int i = 0; i < 3; i++) begin
            beat("half_wait", 32'h0000_2000, 4'b1100, 32'hABCD_0000);
            chk("half_wait_done", {31'd0, st_done}, 32'd0);
            @(negedge clk);
        end
        beat("half_gnt", 32'h0000_2000, 4'b1100, 32'hABCD_0000);
        mem_gnt = 1'b1;
        @(negedge clk);
        chk("half_done", {31'd0, st_done}, 32'd1);
        @(negedge clk);
        chk("half_rdy_back", {31'd0, st_ready}, 32'd1);

        // Half at offset 1 stays inside one word
        issue(32'h0000_0101, 32'h5555_BEEF, 2'b01);
        beat("half_off1", 32'h0000_0100, 4'b0110, 32'h00BE_EF00);
        @(negedge clk);
        chk("half_off1_done", {31'd0, st_done}, 32'd1);
        @(negedge clk);

        // Misaligned word across the top of the address space
        issue(32'hFFFF_FFFD, 32'h1122_3344, 2'b10);
`ifdef MISALIGN_SPLIT_EN
        beat("mis_b0", 32'hFFFF_FFFC, 4'b1110, 32'h2233_4400);
        @(negedge clk);
        beat("mis_b1", 32'h0000_0000, 4'b0001, 32'h0000_0011);
        @(negedge clk);
        chk("mis_done", {31'd0, st_done}, 32'd1);
        chk("mis_err", {31'd0, st_err}, 32'd0);
        @(negedge clk);
        chk("mis_rdy_back", {31'd0, st_ready}, 32'd1);
`else
        chk("mis_err", {31'd0, st_err}, 32'd1);
        chk("mis_done", {31'd0, st_done}, 32'd0);
        chk("mis_req", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        chk("mis_rdy_back", {31'd0, st_ready}, 32'd1);
        chk("mis_err_drop", {31'd0, st_err}, 32'd0);
        chk("mis_req2", {31'd0, mem_req}, 32'd0);
`endif

        // Illegal size
        issue(32'h0000_0000, 32'hFFFF_FFFF, 2'b11);
        chk("ill_err", {31'd0, st_err}, 32'd1);
        chk("ill_req", {31'd0, mem_req}, 32'd0);
        chk("ill_rdy", {31'd0, st_ready}, 32'd0);
        @(negedge clk);
        chk("ill_rdy_back", {31'd0, st_ready}, 32'd1);
        chk("ill_req2", {31'd0, mem_req}, 32'd0);

        // Asynchronous reset while waiting for a grant
        mem_gnt = 1'b0;
        issue(32'h0000_0080, 32'h0BAD_F00D, 2'b10);
        beat("abort_b0", 32'h0000_0080, 4'b1111, 32'h0BAD_F00D);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_req", {31'd0, mem_req}, 32'd0);
        chk("abort_rdy", {31'd0, st_ready}, 32'd0);
        @(negedge clk);
        chk("abort_no_done", {30'd0, st_done, st_err}, 32'd0);
        rst_n   = 1'b1;
        mem_gnt = 1'b1;
        @(negedge clk);
        chk("abort_rdy_back", {31'd0, st_ready}, 32'd1);
        chk("abort_no_done2", {30'd0, st_done, st_err}, 32'd0);
        issue(32'h0000_0040, 32'hCAFE_F00D, 2'b10);
        beat("word40", 32'h0000_0040, 4'b1111, 32'hCAFE_F00D);
        @(negedge clk);
        chk("word40_done", {31'd0, st_done}, 32'd1);
        @(negedge clk);
        chk("word40_rdy_back", {31'd0, st_ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
